// File: rtl/conv3x3_pkg.sv
// Shared widths and output saturation for the 3x3 convolution MAC.
// Build option: CONV3X3_RELU_EN selects a ReLU-clamped unsigned output.
// When it is not defined, the output is a signed 8-bit value.
package conv3x3_pkg;

    localparam int ACC_W    = 22;
    localparam int PROD_W   = 17;
    localparam int NUM_TAPS = 9;
    localparam logic [3:0] BIAS_ADDR = 4'd9;

`ifdef CONV3X3_RELU_EN
    localparam logic signed [ACC_W-1:0] SAT_LO = 22'sd0;
    localparam logic signed [ACC_W-1:0] SAT_HI = 22'sd255;
`else
    localparam logic signed [ACC_W-1:0] SAT_LO = -22'sd128;
    localparam logic signed [ACC_W-1:0] SAT_HI = 22'sd127;
`endif

    // Clamp the scaled accumulator into the 8-bit output range.
    // In ReLU mode, negative values go to 0. In signed mode, the low byte
    // of -128 is 0x80.
    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v < SAT_LO) return SAT_LO[7:0];
        if (v > SAT_HI) return SAT_HI[7:0];
        return v[7:0];
    endfunction

endpackage

// File: rtl/conv3x3_mac_tree.sv
// Two-stage MAC pipeline.
// S1 registers the nine pixel x weight products and the bias.
// S2 registers their sum as a 22-bit signed accumulator.
module conv3x3_mac_tree
    import conv3x3_pkg::*;
(
    input  logic                             jct_i_clk,
    input  logic                             jct_i_rst,
    input  logic [NUM_TAPS-1:0][7:0]         pix,
    input  logic [NUM_TAPS-1:0][7:0]         wt,
    input  logic [15:0]                      bias,
    output logic signed [ACC_W-1:0]          acc
);

    logic signed [PROD_W-1:0] prod_c [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
    logic signed [15:0]       bias_q;
    logic signed [ACC_W-1:0]  sum_c;

    // Unsigned pixel widened with a zero sign bit, times a signed weight.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_c[k] = PROD_W'($signed({1'b0, pix[k]})) * PROD_W'($signed(wt[k]));
        end
    end

    // Bias travels with the products so it lines up with the weights it was written with.
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
            bias_q <= '0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= prod_c[k];
            bias_q <= $signed(bias);
        end
    end

    // Sign-extended sum of the products plus the bias.
    always_comb begin
        sum_c = ACC_W'(bias_q);
        for (int k = 0; k < NUM_TAPS; k++) sum_c = sum_c + ACC_W'(prod_q[k]);
    end

    // S2 accumulator register.
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) acc <= '0;
        else           acc <= sum_c;
    end

endmodule

// File: rtl/conv3x3_mac_150.sv
// 3x3 convolution over the three row taps of the sliding-window stage.
// It emits one 8-bit feature pixel per complete window.
// Build option: CONV3X3_RELU_EN selects a ReLU output; by default the output is signed.
module conv3x3_mac_150
    import conv3x3_pkg::*;
#(
    parameter int P_IMG_W = 150,
    parameter int P_IMG_H = 150,
    parameter int P_SHIFT = 0
)(
    input  logic        jct_i_clk,
    input  logic        jct_i_rst,
    input  logic [7:0]  jct_i_d_data0,
    input  logic [7:0]  jct_i_d_data1,
    input  logic [7:0]  jct_i_d_data2,
    input  logic        jct_i_c_valid,
    input  logic        jct_i_c_wt_we,
    input  logic [3:0]  jct_i_d_wt_addr,
    input  logic [15:0] jct_i_d_wt_data,
    output logic [7:0]  jct_o_d_result,
    output logic        jct_o_c_valid,
    output logic        jct_o_c_last
);

    localparam int COL_W = $clog2(P_IMG_W);
    localparam int ROW_W = $clog2(P_IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(P_IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_IMG_H - 3);

    logic [COL_W-1:0]           col_cnt;
    logic [ROW_W-1:0]           row_cnt;
    logic [2:0][2:0][7:0]       win;
    logic [NUM_TAPS-1:0][7:0]   wt;
    logic [15:0]                bias;
    logic [2:0]                 v_pipe;
    logic [2:0]                 l_pipe;
    logic [NUM_TAPS-1:0][7:0]   pix;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_sh;
    logic                       win_done;
    logic                       frame_end;

    assign win_done  = jct_i_c_valid && (col_cnt >= COL_W'(2));
    assign frame_end = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);

    // Column and row position of the sample being accepted.
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (jct_i_c_valid) begin
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Window shift: row 0 is the top (oldest) row, and a new column enters at col 2.
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            win <= '0;
        end else if (jct_i_c_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= jct_i_d_data2;
            win[1][2] <= jct_i_d_data1;
            win[2][2] <= jct_i_d_data0;
        end
    end

    // Weight and bias bank. Addresses above the bias slot are dropped.
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            wt   <= '0;
            bias <= '0;
        end else if (jct_i_c_wt_we) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (jct_i_d_wt_addr == 4'(k)) wt[k] <= jct_i_d_wt_data[7:0];
            end
            if (jct_i_d_wt_addr == BIAS_ADDR) bias <= jct_i_d_wt_data;
        end
    end

    // Valid and last delay line, aligned to window, S1 and S2.
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            v_pipe <= '0;
            l_pipe <= '0;
        end else begin
            v_pipe <= {v_pipe[1:0], win_done};
            l_pipe <= {l_pipe[1:0], win_done && frame_end};
        end
    end

    // Flatten the window into tap order k = row*3 + col.
    always_comb begin
        pix = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                pix[r*3 + c] = win[r][c];
    end

    conv3x3_mac_tree u_tree (
        .jct_i_clk (jct_i_clk),
        .jct_i_rst (jct_i_rst),
        .pix       (pix),
        .wt        (wt),
        .bias      (bias),
        .acc       (acc)
    );

    // Arithmetic scale ahead of saturation.
    always_comb acc_sh = acc >>> P_SHIFT;

    // Output register. The result is held between pulses.
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            jct_o_d_result <= '0;
            jct_o_c_valid  <= 1'b0;
            jct_o_c_last   <= 1'b0;
        end else begin
            jct_o_c_valid <= v_pipe[2];
            jct_o_c_last  <= l_pipe[2];
            if (v_pipe[2]) jct_o_d_result <= sat8(acc_sh);
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_150.sv
// Scoreboard bench for conv3x3_mac_150 on a small image with P_SHIFT=2.
// The reference keeps per-row pixel history and computes each window sum directly.
module tb_conv3x3_mac_150;

    localparam int W  = 12;
    localparam int H  = 7;
    localparam int SH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d0 = '0, d1 = '0, d2 = '0;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  wa = '0;
    logic [15:0] wd = '0;
    logic [7:0]  o_res;
    logic        o_valid, o_last;

    conv3x3_mac_150 #(.P_IMG_W(W), .P_IMG_H(H), .P_SHIFT(SH)) dut (
        .jct_i_clk       (clk),
        .jct_i_rst       (rst),
        .jct_i_d_data0   (d0),
        .jct_i_d_data1   (d1),
        .jct_i_d_data2   (d2),
        .jct_i_c_valid   (valid),
        .jct_i_c_wt_we   (we),
        .jct_i_d_wt_addr (wa),
        .jct_i_d_wt_data (wd),
        .jct_o_d_result  (o_res),
        .jct_o_c_valid   (o_valid),
        .jct_o_c_last    (o_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] res;
        logic       last;
        int         at;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: weights, bias, position, and pixel history of the current row.
    int wm [9];
    int bm;
    int col_m, row_m;
    int hist [3][W];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_sat(input int v);
`ifdef CONV3X3_RELU_EN
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
`else
        if (v < -128) return 8'h80;
        if (v > 127)  return 8'h7F;
        return 8'(v);
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) wm[k] = 0;
        bm = 0; col_m = 0; row_m = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++) hist[r][c] = 0;
    endtask

    // One clock of stimulus. A write and a sample on the same edge: the sample sees the new value.
    task automatic step(input logic v, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                        input logic w, input logic [3:0] a, input logic [15:0] dat);
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        int acc;
        exp_t e;
        @(negedge clk);
        valid = v; d0 = p0; d1 = p1; d2 = p2; we = w; wa = a; wd = dat;
        if (w) begin
            s8 = dat[7:0]; s16 = dat;
            if (a < 4'd9)       wm[a] = s8;
            else if (a == 4'd9) bm = s16;
        end
        if (v) begin
            hist[0][col_m] = p2;
            hist[1][col_m] = p1;
            hist[2][col_m] = p0;
            if (col_m >= 2) begin
                acc = bm;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        acc += hist[r][col_m - 2 + c] * wm[r*3 + c];
                e.res  = ref_sat(acc >>> SH);
                e.last = (row_m == H-3) && (col_m == W-1);
                e.at   = cyc + 4;
                q.push_back(e);
            end
            if (col_m == W-1) begin
                col_m = 0;
                row_m = (row_m == H-3) ? 0 : row_m + 1;
            end else begin
                col_m++;
            end
        end
    endtask

    task automatic pix(input logic [7:0] p);
        step(1'b1, p, p, p, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] dat);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, a, dat);
    endtask

    task automatic set_all_w(input logic [15:0] w, input logic [15:0] b);
        for (int k = 0; k < 9; k++) wr(4'(k), w);
        wr(4'd9, b);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard, including its timing.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid got=%0h exp=none (t=%0t)", o_res, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", int'(o_res), int'(e.res));
                check("last",   int'(o_last), int'(e.last));
                check("latency_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        model_reset();
        #2;
        check("rst_result", int'(o_res), 0);
        check("rst_valid",  int'(o_valid), 0);
        check("rst_last",   int'(o_last), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Full frame of constant pixels with unit weights.
        set_all_w(16'h0001, 16'h0000);
        for (int i = 0; i < W*(H-2); i++) pix(8'd10);

        // Negative weights: clamp to 0 (ReLU) or a signed result.
        set_all_w(16'hFFFF, 16'h0000);
        for (int i = 0; i < W; i++) pix(8'd10);

        // Saturation in both directions.
        set_all_w(16'h0001, 16'h0000);
        for (int i = 0; i < W; i++) pix(8'd200);
        set_all_w(16'h00FF, 16'h0000);
        for (int i = 0; i < W; i++) pix(8'd200);

        // Centre tap only on a column ramp. Weight 4 cancels the shift by 2.
        set_all_w(16'h0000, 16'h0000);
        wr(4'd4, 16'h0004);
        for (int i = 0; i < W; i++) pix(8'(col_m));

        // Bias only, then a bias change mid-row alongside a sample. Ignored addresses are also written.
        set_all_w(16'h0000, 16'h0100);
        for (int i = 0; i < 5; i++) pix(8'd77);
        step(1'b1, 8'd3, 8'd4, 8'd5, 1'b1, 4'd9, 16'hFE00);
        wr(4'd12, 16'h7FFF);
        wr(4'd15, 16'h00FF);
        for (int i = 0; i < 6; i++) pix(8'd9);

        // Random traffic: gaps in valid, writes mid-frame.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(3) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(9) == 0), 4'($urandom_range(15)), 16'($urandom));

        // Reset mid-row: outputs clear at once, in-flight results are dropped.
        for (int i = 0; i < 5; i++) pix(8'd50);
        @(negedge clk);
        valid = 1'b0; we = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_result", int'(o_res), 0);
        check("midrst_valid",  int'(o_valid), 0);
        check("midrst_last",   int'(o_last), 0);
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        set_all_w(16'h0002, 16'hFFF0);
        for (int i = 0; i < 300; i++)
            step(($urandom_range(4) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(14) == 0), 4'($urandom_range(15)), 16'($urandom));

        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        repeat (8) @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
